// File: rtl/fir_pkg.sv
// Shared types and sizes for the FIR coefficient memory controller.
package fir_pkg;

    localparam int CMEM_AW   = 6;
    localparam int CMEM_DW   = 16;
    localparam int BANK_TAPS = 32;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        BURST = 2'b01
    } cmem_ctrl_state_t;

endpackage

// File: rtl/cmem_rd_seq.sv
// Burst read sequencer: tap pointer, end-of-burst detect and the registered
// coefficient qualifier stage that lines up with the cmem read latency.
module cmem_rd_seq
    import fir_pkg::*;
#(
    parameter int AW = CMEM_AW
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          load,
    input  logic          run,
    input  logic [AW-2:0] n_taps,
    output logic [AW-2:0] rd_ptr,
    output logic          done,
    output logic          coef_valid,
    output logic [AW-2:0] coef_idx,
    output logic          coef_last
);

    localparam logic [AW-2:0] PTR_ONE = 1;

    logic [AW-2:0] rd_ptr_p0;
    logic [AW-2:0] last_ptr_p0;
    logic          vld_p1;
    logic [AW-2:0] idx_p1;
    logic          last_p1;

    // n_taps==0 wraps to the top index, giving a full-bank burst
    always_ff @(posedge clk) begin
        if (load)
            last_ptr_p0 <= n_taps - PTR_ONE;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            rd_ptr_p0 <= '0;
        else if (load)
            rd_ptr_p0 <= '0;
        else if (run)
            rd_ptr_p0 <= rd_ptr_p0 + PTR_ONE;
    end

    assign done = (rd_ptr_p0 == last_ptr_p0);

    // stage p1: qualifiers for the word the cmem returns after this edge
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_p1  <= 1'b0;
            idx_p1  <= '0;
            last_p1 <= 1'b0;
        end else begin
            vld_p1  <= run;
            last_p1 <= run & done;
            if (run)
                idx_p1 <= rd_ptr_p0;
        end
    end

    assign rd_ptr     = rd_ptr_p0;
    assign coef_valid = vld_p1;
    assign coef_idx   = idx_p1;
    assign coef_last  = last_p1;

endmodule

// File: rtl/cmem_ctrl.sv
// Coefficient SRAM sequencer/arbiter: host writes go to the shadow bank,
// FIR bursts read the active bank, swaps only happen between bursts.
module cmem_ctrl
    import fir_pkg::*;
#(
    parameter int AW = CMEM_AW,
    parameter int DW = CMEM_DW
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          wr_valid,
    output logic          wr_ready,
    input  logic [AW-2:0] wr_addr,
    input  logic [DW-1:0] wr_data,
    input  logic          swap_req,
    output logic          bank_act,
    input  logic          start,
    input  logic [AW-2:0] n_taps,
    output logic          busy,
    output logic          coef_valid,
    output logic [AW-2:0] coef_idx,
    output logic          coef_last,
    output logic [DW-1:0] coef_data,
    output logic          start_err,
    output logic          cen,
    output logic          wen,
    output logic [AW-1:0] a,
    output logic [DW-1:0] d,
    input  logic [DW-1:0] q
);

    cmem_ctrl_state_t state, state_nxt;

    logic          swap_pend;
    logic          bank_tgl;
    logic          pend_set;
    logic          pend_clr;
    logic          serr_nxt;
    logic          rd_load;
    logic          rd_run;
    logic          rd_done;
    logic [AW-2:0] rd_ptr;

    cmem_rd_seq #(.AW(AW)) u_rd_seq (
        .clk        (clk),
        .rst_n      (rst_n),
        .load       (rd_load),
        .run        (rd_run),
        .n_taps     (n_taps),
        .rd_ptr     (rd_ptr),
        .done       (rd_done),
        .coef_valid (coef_valid),
        .coef_idx   (coef_idx),
        .coef_last  (coef_last)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    // cmem port is held quiet while rst_n is low, whatever the host drives
    always_comb begin
        state_nxt = state;
        wr_ready  = 1'b0;
        busy      = 1'b0;
        cen       = 1'b1;
        wen       = 1'b1;
        a         = '0;
        d         = '0;
        rd_load   = 1'b0;
        rd_run    = 1'b0;
        bank_tgl  = 1'b0;
        pend_set  = 1'b0;
        pend_clr  = 1'b0;
        serr_nxt  = 1'b0;
        if (rst_n) begin
            case (state)
                IDLE: begin
                    wr_ready = ~start;
                    if (start) begin
                        state_nxt = BURST;
                        rd_load   = 1'b1;
                        pend_set  = swap_req;
                    end else begin
                        bank_tgl = swap_req;
                        if (wr_valid) begin
                            cen = 1'b0;
                            wen = 1'b0;
                            a   = {~bank_act, wr_addr};
                            d   = wr_data;
                        end
                    end
                end
                BURST: begin
                    busy     = 1'b1;
                    cen      = 1'b0;
                    a        = {bank_act, rd_ptr};
                    rd_run   = 1'b1;
                    serr_nxt = start;
                    pend_set = swap_req;
                    if (rd_done) begin
                        state_nxt = IDLE;
                        bank_tgl  = swap_pend | swap_req;
                        pend_clr  = 1'b1;
                    end
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bank_act  <= 1'b0;
            swap_pend <= 1'b0;
            start_err <= 1'b0;
        end else begin
            start_err <= serr_nxt;
            if (bank_tgl)
                bank_act <= ~bank_act;
            if (pend_clr)
                swap_pend <= 1'b0;
            else if (pend_set)
                swap_pend <= 1'b1;
        end
    end

    assign coef_data = q;

endmodule

// File: tb/tb_cmem_ctrl.sv
// Bench for cmem_ctrl with a behavioural 64x16 synchronous SRAM and a
// bank-level reference model of the coefficient store.
module tb_cmem_ctrl;
    import fir_pkg::*;

    localparam int AW = CMEM_AW;
    localparam int DW = CMEM_DW;

    logic          clk;
    logic          rst_n;
    logic          wr_valid;
    logic          wr_ready;
    logic [AW-2:0] wr_addr;
    logic [DW-1:0] wr_data;
    logic          swap_req;
    logic          bank_act;
    logic          start;
    logic [AW-2:0] n_taps;
    logic          busy;
    logic          coef_valid;
    logic [AW-2:0] coef_idx;
    logic          coef_last;
    logic [DW-1:0] coef_data;
    logic          start_err;
    logic          cen;
    logic          wen;
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    logic [DW-1:0] q;

    cmem_ctrl #(.AW(AW), .DW(DW)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .wr_valid   (wr_valid),
        .wr_ready   (wr_ready),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .swap_req   (swap_req),
        .bank_act   (bank_act),
        .start      (start),
        .n_taps     (n_taps),
        .busy       (busy),
        .coef_valid (coef_valid),
        .coef_idx   (coef_idx),
        .coef_last  (coef_last),
        .coef_data  (coef_data),
        .start_err  (start_err),
        .cen        (cen),
        .wen        (wen),
        .a          (a),
        .d          (d),
        .q          (q)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // synchronous single-port SRAM
    logic [DW-1:0] mem [0:63];
    always @(posedge clk) begin
        if (!cen) begin
            if (!wen)
                mem[a] <= d;
            else
                q <= mem[a];
        end
    end

    // reference model: full memory image and the active bank
    logic [DW-1:0] exp_mem [0:63];
    logic          m_bank;
    int            checks;
    int            errors;

    typedef struct {
        logic [4:0] n_taps;
        int         exp_n;
    } bvec_t;
    bvec_t tbl [6];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic do_write(input logic [4:0] ad, input logic [15:0] dt, input bit sw);
        wr_valid = 1'b1; wr_addr = ad; wr_data = dt; swap_req = sw;
        #1;
        chk("wr_ready", wr_ready, 1);
        chk("wr_port", {cen, wen, a, d}, {2'b00, ~m_bank, ad, dt});
        @(negedge clk);
        wr_valid = 1'b0; swap_req = 1'b0;
        exp_mem[{~m_bank, ad}] = dt;
        if (sw) m_bank = ~m_bank;
        #1;
        chk("bank_after_wr", bank_act, m_bank);
    endtask

    task automatic do_swap();
        swap_req = 1'b1;
        #1;
        chk("swap_idle_port", {cen, wen}, 2'b11);
        @(negedge clk);
        swap_req = 1'b0;
        m_bank = ~m_bank;
        #1;
        chk("bank_after_swap", bank_act, m_bank);
    endtask

    // Issue one burst; optionally a swap request or a stray start while busy.
    task automatic run_burst(input logic [4:0] nt, input int exp_n, input int swap_at,
                             input int start_at, input bit sw_start);
        logic b;
        bit   pend;
        bit   serr;
        bit   fin;
        int   cnt;
        b = m_bank; pend = sw_start; serr = 1'b0; fin = 1'b0; cnt = 0;
        start = 1'b1; n_taps = nt; swap_req = sw_start;
        #1;
        chk("start_wr_ready", wr_ready, 0);
        chk("start_no_access", {cen, wen}, 2'b11);
        for (int cyc = 0; cyc < 40 && !fin; cyc++) begin
            @(negedge clk);
            start = 1'b0; swap_req = 1'b0; n_taps = 5'($urandom_range(0, 31));
            #1;
            if (coef_valid) begin
                chk("coef_idx", coef_idx, cnt[4:0]);
                chk("coef_data", coef_data, exp_mem[{b, cnt[4:0]}]);
                chk("coef_last", coef_last, cnt == exp_n - 1);
                cnt++;
            end
            chk("start_err", start_err, serr);
            chk("busy", busy, cnt < exp_n);
            if (cnt < exp_n) begin
                chk("rd_port", {cen, wen, a[5], wr_ready}, {2'b01, b, 1'b0});
                chk("bank_hold", bank_act, b);
                serr = (cnt == start_at);
                start = serr;
                if (cnt == swap_at) begin
                    swap_req = 1'b1;
                    pend = 1'b1;
                end
            end else begin
                fin = 1'b1;
                chk("bank_end", bank_act, b ^ pend);
                if (wr_valid)
                    chk("post_burst_write", {cen, wen, a}, {2'b00, ~(b ^ pend), wr_addr});
            end
        end
        start = 1'b0; swap_req = 1'b0;
        if (!fin) begin
            checks++;
            errors++;
            $display("FAIL burst_timeout: got %0d taps, expected %0d", cnt, exp_n);
        end
        @(negedge clk);
        #1;
        chk("no_extra_valid", coef_valid, 0);
        chk("start_err_clear", start_err, 0);
        m_bank = b ^ pend;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [4:0] nt;
        int         n;
        int         sa;
        int         st;
        bit         hit;

        checks = 0; errors = 0; m_bank = 1'b0;
        for (int i = 0; i < 64; i++) begin
            mem[i] = '0;
            exp_mem[i] = '0;
        end
        rst_n = 1'b0; wr_valid = 1'b1; wr_addr = 5'd9; wr_data = 16'hbeef;
        swap_req = 1'b0; start = 1'b0; n_taps = '0;

        // reset: port quiet even with a pending host write
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("rst_port", {cen, wen, wr_ready}, 3'b110);
            chk("rst_coef", {coef_valid, coef_last, coef_idx, busy, start_err}, '0);
            chk("rst_bank", bank_act, 0);
            @(negedge clk);
        end
        wr_valid = 1'b0;
        rst_n = 1'b1;
        @(negedge clk);
        #1;
        chk("idle_cen", {cen, wen, wr_ready}, 3'b111);

        // load taps 0..7 into the shadow bank, swap, read them back
        for (int i = 0; i < 8; i++)
            do_write(5'(i), 16'(100 + i), 1'b0);
        do_swap();
        run_burst(5'd8, 8, -1, -1, 1'b0);

        // fill the other bank, make it active, then table of burst lengths
        for (int i = 0; i < 32; i++)
            do_write(5'(i), 16'($urandom), 1'b0);
        do_swap();
        tbl[0] = '{5'd1, 1};
        tbl[1] = '{5'd2, 2};
        tbl[2] = '{5'd7, 7};
        tbl[3] = '{5'd31, 31};
        tbl[4] = '{5'd0, 32};
        tbl[5] = '{5'd16, 16};
        for (int i = 0; i < 6; i++)
            run_burst(tbl[i].n_taps, tbl[i].exp_n, -1, -1, 1'b0);

        // write colliding with start stalls until the first idle cycle
        wr_valid = 1'b1; wr_addr = 5'd3; wr_data = 16'd350;
        run_burst(5'd4, 4, -1, -1, 1'b0);
        wr_valid = 1'b0;
        exp_mem[{~m_bank, 5'd3}] = 16'd350;
        do_swap();
        run_burst(5'd4, 4, -1, -1, 1'b0);

        // swap during a full burst, stray start during a burst, swap with start
        run_burst(5'd0, 32, 10, -1, 1'b0);
        run_burst(5'd12, 12, -1, 4, 1'b0);
        run_burst(5'd6, 6, -1, -1, 1'b1);

        // reset in the middle of a burst
        if (!m_bank) do_swap();
        start = 1'b1; n_taps = 5'd16;
        @(negedge clk);
        start = 1'b0;
        hit = 1'b0;
        for (int i = 0; i < 20 && !hit; i++) begin
            @(negedge clk);
            hit = coef_valid && (coef_idx == 5'd5);
        end
        chk("tap5_seen", hit, 1);
        rst_n = 1'b0;
        #1;
        chk("midrst_port", {cen, wen, busy}, 3'b110);
        chk("midrst_coef", {coef_valid, coef_idx}, '0);
        chk("midrst_bank", bank_act, 0);
        m_bank = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        #1;
        chk("post_rst_quiet", {coef_valid, busy}, 2'b00);
        run_burst(5'd4, 4, -1, -1, 1'b0);

        // randomized mix of writes, swaps and bursts
        for (int i = 0; i < 30; i++) begin
            case ($urandom_range(0, 2))
                0: do_write(5'($urandom_range(0, 31)), 16'($urandom), $urandom_range(0, 3) == 0);
                1: begin
                    nt = 5'($urandom_range(0, 31));
                    n  = (nt == 0) ? BANK_TAPS : int'(nt);
                    sa = ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, n - 1)) : -1;
                    st = ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, n - 1)) : -1;
                    run_burst(nt, n, sa, st, $urandom_range(0, 3) == 0);
                end
                default: do_swap();
            endcase
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
